// File: rtl/bp_be_dcache_miss_queue_if.sv
// rtl/bp_be_dcache_miss_queue_if.sv - fast-path / LCE handshake bundle for the D$ miss queue
interface bp_be_dcache_miss_queue_if #(
    parameter int req_width_p       = 128,
    parameter int metadata_width_p  = 4,
    parameter int max_outstanding_p = 1
);
    localparam int out_w = $clog2(max_outstanding_p + 1);

    logic [req_width_p-1:0]      req_i;
    logic                        req_v_i;
    logic                        req_ready_o;
    logic [metadata_width_p-1:0] metadata_i;
    logic                        metadata_v_i;
    logic [req_width_p-1:0]      cache_req_o;
    logic                        cache_req_v_o;
    logic                        cache_req_ready_i;
    logic [metadata_width_p-1:0] cache_req_metadata_o;
    logic                        cache_req_metadata_v_o;
    logic                        cache_req_complete_i;
    logic                        credits_full_i;
    logic [out_w-1:0]            outstanding_o;
    logic                        empty_o;
    logic                        full_o;

    modport slave (
        input  req_i, req_v_i, metadata_i, metadata_v_i,
               cache_req_ready_i, cache_req_complete_i, credits_full_i,
        output req_ready_o, cache_req_o, cache_req_v_o, cache_req_metadata_o,
               cache_req_metadata_v_o, outstanding_o, empty_o, full_o
    );

    modport master (
        output req_i, req_v_i, metadata_i, metadata_v_i,
               cache_req_ready_i, cache_req_complete_i, credits_full_i,
        input  req_ready_o, cache_req_o, cache_req_v_o, cache_req_metadata_o,
               cache_req_metadata_v_o, outstanding_o, empty_o, full_o
    );
endinterface

// File: rtl/bp_be_dcache_miss_queue.sv
// rtl/bp_be_dcache_miss_queue.sv - pairs D$ miss requests with late metadata and throttles issue to the LCE
module bp_be_dcache_miss_queue #(
    parameter int els_p             = 4,
    parameter int req_width_p       = 128,
    parameter int metadata_width_p  = 4,
    parameter int max_outstanding_p = 1
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    bp_be_dcache_miss_queue_if.slave bus
);
    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = $clog2(els_p + 1);
    localparam int out_w = $clog2(max_outstanding_p + 1);

    logic [req_width_p-1:0]      r_req [els_p];
    logic [metadata_width_p-1:0] r_md  [els_p];
    logic [els_p-1:0]            r_md_v;
    logic [ptr_w-1:0]            r_wptr, r_mptr, r_rptr;
    logic [cnt_w-1:0]            r_count;
    logic [cnt_w-1:0]            r_pending;
    logic [out_w-1:0]            r_out;
    logic [metadata_width_p-1:0] r_md_out;
    logic                        r_md_pulse;

    logic w_full, w_empty, w_enq, w_fill, w_issue, w_deq, w_cmp;

    function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_full  = (r_count == cnt_w'(els_p));
    assign w_empty = (r_count == '0);
    assign w_enq   = bus.req_v_i & ~w_full;
    // r_pending counts only entries already held, so a same-cycle enqueue is never filled
    assign w_fill  = bus.metadata_v_i & (r_pending != '0);
    assign w_issue = ~w_empty & r_md_v[r_rptr]
                   & (r_out < out_w'(max_outstanding_p)) & ~bus.credits_full_i;
    assign w_deq   = w_issue & bus.cache_req_ready_i;
    assign w_cmp   = bus.cache_req_complete_i & (r_out != '0);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < els_p; i++) begin
                r_req[i] <= '0;
                r_md[i]  <= '0;
            end
            r_md_v <= '0;
        end else begin
            if (w_enq) begin
                r_req[r_wptr]  <= bus.req_i;
                r_md_v[r_wptr] <= 1'b0;
            end
            if (w_fill) begin
                r_md[r_mptr]   <= bus.metadata_i;
                r_md_v[r_mptr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wptr     <= '0;
            r_mptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_pending  <= '0;
            r_out      <= '0;
            r_md_out   <= '0;
            r_md_pulse <= 1'b0;
        end else begin
            if (w_enq)  r_wptr <= next_ptr(r_wptr);
            if (w_fill) r_mptr <= next_ptr(r_mptr);
            if (w_deq)  r_rptr <= next_ptr(r_rptr);

            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            case ({w_enq, w_fill})
                2'b10:   r_pending <= r_pending + 1'b1;
                2'b01:   r_pending <= r_pending - 1'b1;
                default: r_pending <= r_pending;
            endcase

            if (w_deq && !w_cmp)      r_out <= r_out + 1'b1;
            else if (w_cmp && !w_deq) r_out <= r_out - 1'b1;

            r_md_pulse <= w_deq;
            if (w_deq) r_md_out <= r_md[r_rptr];
        end
    end

    assign bus.req_ready_o            = ~w_full;
    assign bus.cache_req_o            = r_req[r_rptr];
    assign bus.cache_req_v_o          = w_issue;
    assign bus.cache_req_metadata_o   = r_md_out;
    assign bus.cache_req_metadata_v_o = r_md_pulse;
    assign bus.outstanding_o          = r_out;
    assign bus.empty_o                = w_empty;
    assign bus.full_o                 = w_full;
endmodule

// File: tb/tb_bp_be_dcache_miss_queue.sv
// tb/tb_bp_be_dcache_miss_queue.sv - directed self-checking bench for the D$ miss queue
module tb_bp_be_dcache_miss_queue;
    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    bp_be_dcache_miss_queue_if #(.req_width_p(128), .metadata_width_p(4), .max_outstanding_p(1)) bus ();

    bp_be_dcache_miss_queue #(
        .els_p(4), .req_width_p(128), .metadata_width_p(4), .max_outstanding_p(1)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [127:0] r);
        bus.req_i   = r;
        bus.req_v_i = 1'b1;
        tick();
        bus.req_v_i = 1'b0;
    endtask

    task automatic md(input logic [3:0] m);
        bus.metadata_i   = m;
        bus.metadata_v_i = 1'b1;
        tick();
        bus.metadata_v_i = 1'b0;
    endtask

    task automatic issue_one(input string tag, input logic [127:0] exp_req, input logic [3:0] exp_md);
        int k;
        k = 0;
        bus.cache_req_ready_i = 1'b1;
        #1;
        while (!bus.cache_req_v_o && k < 20) begin
            tick();
            #1;
            k++;
        end
        check({tag, "_v"}, bus.cache_req_v_o, 1);
        check({tag, "_req"}, bus.cache_req_o, exp_req);
        tick();
        bus.cache_req_ready_i = 1'b0;
        #1;
        check({tag, "_mdv"}, bus.cache_req_metadata_v_o, 1);
        check({tag, "_md"}, bus.cache_req_metadata_o, exp_md);
        check({tag, "_out1"}, bus.outstanding_o, 1);
        bus.cache_req_complete_i = 1'b1;
        tick();
        bus.cache_req_complete_i = 1'b0;
        #1;
        check({tag, "_out0"}, bus.outstanding_o, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy"}, bus.req_ready_o, 1);
        check({tag, "_v"}, bus.cache_req_v_o, 0);
        check({tag, "_mdv"}, bus.cache_req_metadata_v_o, 0);
        check({tag, "_out"}, bus.outstanding_o, 0);
        check({tag, "_empty"}, bus.empty_o, 1);
        check({tag, "_full"}, bus.full_o, 0);
        check({tag, "_reqx"}, $isunknown(bus.cache_req_o), 0);
        check({tag, "_mdx"}, $isunknown(bus.cache_req_metadata_o), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n                    = 1'b0;
        bus.req_i                = '0;
        bus.req_v_i              = 1'b0;
        bus.metadata_i           = '0;
        bus.metadata_v_i         = 1'b0;
        bus.cache_req_ready_i    = 1'b0;
        bus.cache_req_complete_i = 1'b0;
        bus.credits_full_i       = 1'b0;
        #1;
        check_reset_outputs("rst");
        tick();
        tick();
        rst_n = 1'b1;

        // single miss: N enqueue, N+1 metadata, N+2 valid, N+3 pulse
        bus.req_i   = 128'hA;
        bus.req_v_i = 1'b1;
        #1;
        check("miss_rdy", bus.req_ready_o, 1);
        tick();
        bus.req_v_i      = 1'b0;
        bus.metadata_i   = 4'h5;
        bus.metadata_v_i = 1'b1;
        #1;
        check("miss_v_c1", bus.cache_req_v_o, 0);
        tick();
        bus.metadata_v_i      = 1'b0;
        bus.cache_req_ready_i = 1'b1;
        #1;
        check("miss_v_c2", bus.cache_req_v_o, 1);
        check("miss_req_c2", bus.cache_req_o, 128'hA);
        tick();
        bus.cache_req_ready_i = 1'b0;
        #1;
        check("miss_mdv_c3", bus.cache_req_metadata_v_o, 1);
        check("miss_md_c3", bus.cache_req_metadata_o, 4'h5);
        check("miss_out_c3", bus.outstanding_o, 1);
        check("miss_empty_c3", bus.empty_o, 1);
        tick();
        #1;
        check("miss_mdv_c4", bus.cache_req_metadata_v_o, 0);
        check("miss_out_c4", bus.outstanding_o, 1);
        bus.cache_req_complete_i = 1'b1;
        tick();
        bus.cache_req_complete_i = 1'b0;
        #1;
        check("miss_out_done", bus.outstanding_o, 0);

        // fill to full without metadata, push while full is dropped
        for (int i = 0; i < 4; i++) push(128'h10 + i);
        #1;
        check("full_full", bus.full_o, 1);
        check("full_rdy", bus.req_ready_o, 0);
        check("full_v", bus.cache_req_v_o, 0);
        push(128'h99);
        bus.cache_req_complete_i = 1'b1;
        tick();
        bus.cache_req_complete_i = 1'b0;
        #1;
        check("spur_cmp_out", bus.outstanding_o, 0);
        check("full_still", bus.full_o, 1);
        for (int i = 0; i < 4; i++) md(4'(i + 1));
        issue_one("fifo0", 128'h10, 4'h1);
        issue_one("fifo1", 128'h11, 4'h2);
        issue_one("fifo2", 128'h12, 4'h3);
        issue_one("fifo3", 128'h13, 4'h4);
        check("fifo_empty", bus.empty_o, 1);

        // credits_full withdraws valid in the same cycle
        push(128'h20);
        md(4'h7);
        #1;
        check("cred_v_before", bus.cache_req_v_o, 1);
        bus.credits_full_i    = 1'b1;
        bus.cache_req_ready_i = 1'b1;
        #1;
        check("cred_v_blocked", bus.cache_req_v_o, 0);
        tick();
        bus.cache_req_ready_i = 1'b0;
        #1;
        check("cred_no_mdv", bus.cache_req_metadata_v_o, 0);
        check("cred_no_out", bus.outstanding_o, 0);
        check("cred_held", bus.empty_o, 0);
        bus.credits_full_i = 1'b0;
        issue_one("cred", 128'h20, 4'h7);

        // metadata while empty is dropped
        md(4'hF);
        #1;
        check("spur_md_empty", bus.empty_o, 1);
        push(128'h30);
        md(4'h3);
        issue_one("spur", 128'h30, 4'h3);

        // enqueue + dequeue at occupancy 1
        push(128'h40);
        md(4'h1);
        #1;
        check("occ1_v", bus.cache_req_v_o, 1);
        bus.req_i             = 128'h41;
        bus.req_v_i           = 1'b1;
        bus.cache_req_ready_i = 1'b1;
        #1;
        check("occ1_rdy", bus.req_ready_o, 1);
        tick();
        bus.req_v_i           = 1'b0;
        bus.cache_req_ready_i = 1'b0;
        #1;
        check("occ1_mdv", bus.cache_req_metadata_v_o, 1);
        check("occ1_md", bus.cache_req_metadata_o, 4'h1);
        check("occ1_empty", bus.empty_o, 0);
        check("occ1_full", bus.full_o, 0);
        bus.cache_req_complete_i = 1'b1;
        tick();
        bus.cache_req_complete_i = 1'b0;
        md(4'h2);
        issue_one("occ1b", 128'h41, 4'h2);
        check("occ1_empty_end", bus.empty_o, 1);

        // dequeue at full with a blocked enqueue, then wrap order
        for (int i = 0; i < 4; i++) push(128'h50 + i);
        for (int i = 0; i < 4; i++) md(4'(i + 5));
        #1;
        check("atfull_full", bus.full_o, 1);
        check("atfull_v", bus.cache_req_v_o, 1);
        check("atfull_head", bus.cache_req_o, 128'h50);
        bus.req_i             = 128'h54;
        bus.req_v_i           = 1'b1;
        bus.cache_req_ready_i = 1'b1;
        #1;
        check("atfull_rdy", bus.req_ready_o, 0);
        tick();
        bus.req_v_i           = 1'b0;
        bus.cache_req_ready_i = 1'b0;
        #1;
        check("atfull_notfull", bus.full_o, 0);
        check("atfull_md", bus.cache_req_metadata_o, 4'h5);
        bus.cache_req_complete_i = 1'b1;
        tick();
        bus.cache_req_complete_i = 1'b0;
        push(128'h54);
        md(4'h9);
        #1;
        check("wrap_full", bus.full_o, 1);
        issue_one("wrap1", 128'h51, 4'h6);
        issue_one("wrap2", 128'h52, 4'h7);
        issue_one("wrap3", 128'h53, 4'h8);
        issue_one("wrap4", 128'h54, 4'h9);

        // async reset with 3 queued and 1 outstanding
        for (int i = 0; i < 4; i++) push(128'h60 + i);
        for (int i = 0; i < 4; i++) md(4'(i + 10));
        bus.cache_req_ready_i = 1'b1;
        #1;
        check("mrst_v", bus.cache_req_v_o, 1);
        tick();
        bus.cache_req_ready_i = 1'b0;
        #1;
        check("mrst_pulse", bus.cache_req_metadata_v_o, 1);
        check("mrst_out", bus.outstanding_o, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mrst");
        tick();
        rst_n = 1'b1;
        #1;
        check("mrst_rel_mdv", bus.cache_req_metadata_v_o, 0);
        check("mrst_rel_empty", bus.empty_o, 1);
        push(128'h70);
        md(4'h9);
        issue_one("post_rst", 128'h70, 4'h9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
